// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

    localparam int N_REQ = 2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational 2-way round-robin grant
module rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  logic             last_grant,
    output logic [N_REQ-1:0] grant
);

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = valid;
        if (valid[REQ_CPU] && valid[REQ_DBG]) begin
            grant = (last_grant == REQ_DBG) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter and access sequencer for a synchronous-read memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32,
    parameter int ADDR_W      = $clog2(MEM_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_valid_0,
    output logic                   req_ready_0,
    input  logic                   req_we_0,
    input  logic [ADDR_W-1:0]      req_addr_0,
    input  logic [DATA_LENGTH-1:0] req_wdata_0,
    output logic                   rsp_valid_0,
    output logic [DATA_LENGTH-1:0] rsp_rdata_0,

    input  logic                   req_valid_1,
    output logic                   req_ready_1,
    input  logic                   req_we_1,
    input  logic [ADDR_W-1:0]      req_addr_1,
    input  logic [DATA_LENGTH-1:0] req_wdata_1,
    output logic                   rsp_valid_1,
    output logic [DATA_LENGTH-1:0] rsp_rdata_1,

    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    output logic                   mem_we,
    input  logic [DATA_LENGTH-1:0] mem_rdata,

    output logic                   busy,
    output logic                   grant_id
);

    arb_state_t                         state_q, state_d;
    logic                               last_grant_q, last_grant_d;
    logic                               owner_q, owner_d;
    logic                               we_q, we_d;
    logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
    logic [DATA_LENGTH-1:0]             mem_wdata_q, mem_wdata_d;
    logic                               mem_we_q, mem_we_d;
    logic [N_REQ-1:0]                   rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][DATA_LENGTH-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] req_ready;
    logic             sel;

    rr_arbiter u_rr (
        .valid      ({req_valid_1, req_valid_0}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Requests are only accepted in IDLE; held off entirely while reset is high.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign sel       = req_ready[REQ_DBG];

    // Next-state logic: latch the winning request, pulse the write, capture read data at end of WAIT.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    owner_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel ? req_we_1    : req_we_0;
                    mem_addr_d   = sel ? req_addr_1  : req_addr_0;
                    mem_wdata_d  = sel ? req_wdata_1 : req_wdata_0;
                    mem_we_d     = sel ? req_we_1    : req_we_0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            WAIT: begin
                rsp_rdata_d[owner_q] = we_q ? '0 : mem_rdata;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction and clears mem_we at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_DBG;
            owner_q      <= REQ_CPU;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req_ready_0 = req_ready[REQ_CPU];
    assign req_ready_1 = req_ready[REQ_DBG];
    assign rsp_valid_0 = rsp_valid_q[REQ_CPU];
    assign rsp_valid_1 = rsp_valid_q[REQ_DBG];
    assign rsp_rdata_0 = rsp_rdata_q[REQ_CPU];
    assign rsp_rdata_1 = rsp_rdata_q[REQ_DBG];
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DL = 32;
    localparam int ML = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_0 = 1'b0, req_we_0 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0;
    logic [DL-1:0] req_wdata_0 = '0;
    logic          req_valid_1 = 1'b0, req_we_1 = 1'b0;
    logic [AW-1:0] req_addr_1 = '0;
    logic [DL-1:0] req_wdata_1 = '0;
    logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic [DL-1:0] rsp_rdata_0, rsp_rdata_1;
    logic [AW-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_we;
    logic [DL-1:0] mem_rdata = '0;
    logic          busy, grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rsp0_cnt = 0;
    logic rule_viol = 1'b0;

    logic [DL-1:0] mem [ML];

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] a1;
        logic [DL-1:0] wd1;
        logic          we2;
        logic          rv_off;
        logic          rv_own;
        logic          rv_oth;
        logic [DL-1:0] rd;
        logic          busy4;
    } obs_t;

    mem_arbiter #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < ML; i++) mem[i] = '0;
    end

    // Synchronous-read, single-port memory model
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (rsp_valid_0) rsp0_cnt <= rsp0_cnt + 1;
    end

    // Requester rule: a pending request keeps valid and payload until accepted
    logic          pend0 = 1'b0, pend1 = 1'b0;
    logic [DL+AW:0] pay0 = '0, pay1 = '0;
    always @(posedge clk) begin
        if (!rst && pend0 && !(req_valid_0 && pay0 == {req_we_0, req_addr_0, req_wdata_0})) rule_viol <= 1'b1;
        if (!rst && pend1 && !(req_valid_1 && pay1 == {req_we_1, req_addr_1, req_wdata_1})) rule_viol <= 1'b1;
        pend0 <= req_valid_0 && !req_ready_0 && !rst;
        pend1 <= req_valid_1 && !req_ready_1 && !rst;
        pay0  <= {req_we_0, req_addr_0, req_wdata_0};
        pay1  <= {req_we_1, req_addr_1, req_wdata_1};
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1);
    end

    task automatic start_req(input bit r, input bit we, input logic [AW-1:0] a,
                             input logic [DL-1:0] d, output bit ok, output int hs);
        @(negedge clk);
        if (r) begin
            req_we_1 = we; req_addr_1 = a; req_wdata_1 = d; req_valid_1 = 1'b1;
        end else begin
            req_we_0 = we; req_addr_0 = a; req_wdata_0 = d; req_valid_0 = 1'b1;
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (r ? req_ready_1 : req_ready_0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        hs = -1;
        if (ok) begin
            @(posedge clk);
            #1;
            hs = cyc;
        end
        if (r) req_valid_1 = 1'b0;
        else   req_valid_0 = 1'b0;
    endtask

    task automatic collect(input bit r, output obs_t o);
        @(negedge clk);
        o.we1 = mem_we; o.a1 = mem_addr; o.wd1 = mem_wdata;
        o.rv_off = r ? rsp_valid_1 : rsp_valid_0;
        @(negedge clk);
        o.we2 = mem_we;
        o.rv_off = o.rv_off | (r ? rsp_valid_1 : rsp_valid_0);
        @(negedge clk);
        o.rv_own = r ? rsp_valid_1 : rsp_valid_0;
        o.rv_oth = r ? rsp_valid_0 : rsp_valid_1;
        o.rd     = r ? rsp_rdata_1 : rsp_rdata_0;
        @(negedge clk);
        o.busy4  = busy;
        o.rv_off = o.rv_off | (r ? rsp_valid_1 : rsp_valid_0);
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 5'd1;
        req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 5'd2;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready_0 !== 1'b0) begin n_fail++; $display("FAIL rst_ready_0 got %b need 0", req_ready_0); end
        n_checks++; if (req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL rst_ready_1 got %b need 0", req_ready_1); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr got %h need 0", mem_addr); end
        n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata got %h need 0", mem_wdata); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b need 0", mem_we); end
        n_checks++; if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid got %b need 00", {rsp_valid_0, rsp_valid_1}); end
        n_checks++; if (rsp_rdata_0 !== '0) begin n_fail++; $display("FAIL rst_rsp_rdata_0 got %h need 0", rsp_rdata_0); end
        n_checks++; if (rsp_rdata_1 !== '0) begin n_fail++; $display("FAIL rst_rsp_rdata_1 got %h need 0", rsp_rdata_1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b need 0", busy); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant_id got %b need 0", grant_id); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if ({req_ready_1, req_ready_0} !== 2'b01) begin n_fail++; $display("FAIL first_tie_ready got %b need 01", {req_ready_1, req_ready_0}); end
        @(posedge clk);
        #1;
        req_valid_0 = 1'b0;
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL first_tie_grant got %b need 0", grant_id); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy got %b need 1", busy); end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (req_ready_1) begin ok = 1'b1; break; end
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_second_accept got %b need 1", ok); end
        @(posedge clk); #1;
        req_valid_1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_read();
        bit ok; int hs; obs_t o;
        start_req(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, ok, hs);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_accept got %b need 1", ok); end
        collect(1'b0, o);
        n_checks++; if (o.we1 !== 1'b1) begin n_fail++; $display("FAIL wr_we_n1 got %b need 1", o.we1); end
        n_checks++; if (o.a1 !== 5'd5) begin n_fail++; $display("FAIL wr_addr got %0d need 5", o.a1); end
        n_checks++; if (o.wd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata got %h need deadbeef", o.wd1); end
        n_checks++; if (o.we2 !== 1'b0) begin n_fail++; $display("FAIL wr_we_n2 got %b need 0", o.we2); end
        n_checks++; if (o.rv_own !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid got %b need 1", o.rv_own); end
        n_checks++; if (o.rv_oth !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_other got %b need 0", o.rv_oth); end
        n_checks++; if (o.rv_off !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse got %b need 0", o.rv_off); end
        n_checks++; if (o.rd !== '0) begin n_fail++; $display("FAIL wr_rsp_rdata got %h need 0", o.rd); end
        n_checks++; if (o.busy4 !== 1'b0) begin n_fail++; $display("FAIL wr_busy_n4 got %b need 0", o.busy4); end
        start_req(1'b0, 1'b0, 5'd5, 32'h0, ok, hs);
        collect(1'b0, o);
        n_checks++; if (o.we1 !== 1'b0) begin n_fail++; $display("FAIL rd_we got %b need 0", o.we1); end
        n_checks++; if (o.rv_own !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid got %b need 1", o.rv_own); end
        n_checks++; if (o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got %h need deadbeef", o.rd); end
    endtask

    task automatic test_round_robin();
        bit ok; bit got; int hs; int prev;
        @(negedge clk);
        rst = 1'b1;
        req_we_0 = 1'b0; req_addr_0 = 5'd0; req_valid_0 = 1'b1;
        req_we_1 = 1'b0; req_addr_1 = 5'd1; req_valid_1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (req_ready_0 || req_ready_1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            got = req_ready_1;
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_ready_%0d got %b need 1", i, ok); end
            n_checks++; if (got !== 1'(i % 2)) begin n_fail++; $display("FAIL rr_grant_%0d got %b need %0d", i, got, i % 2); end
            @(posedge clk); #1;
            hs = cyc;
            n_checks++; if (grant_id !== 1'(i % 2)) begin n_fail++; $display("FAIL rr_grant_id_%0d got %b need %0d", i, grant_id, i % 2); end
            if (i > 0) begin
                n_checks++; if (hs - prev !== 4) begin n_fail++; $display("FAIL rr_spacing_%0d got %0d need 4", i, hs - prev); end
            end
            prev = hs;
            if (i >= 5) begin
                if (got) req_valid_1 = 1'b0;
                else     req_valid_0 = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_loader_fill();
        bit ok; int hs; obs_t o; int base;
        base = rsp0_cnt;
        for (int a = 0; a < ML; a++) begin
            start_req(1'b1, 1'b1, AW'(a), DL'(a * 3), ok, hs);
            collect(1'b1, o);
        end
        for (int a = 0; a < ML; a++) begin
            start_req(1'b1, 1'b0, AW'(a), 32'h0, ok, hs);
            collect(1'b1, o);
            n_checks++; if (o.rv_own !== 1'b1 || o.rd !== DL'(a * 3)) begin n_fail++; $display("FAIL fill_read_%0d got v=%b d=%0d need v=1 d=%0d", a, o.rv_own, o.rd, a * 3); end
        end
        n_checks++; if (rsp0_cnt !== base) begin n_fail++; $display("FAIL fill_rsp0_quiet got %0d pulses need 0", rsp0_cnt - base); end
    endtask

    task automatic test_reset_during_access();
        bit ok; int hs; obs_t o; int base;
        start_req(1'b0, 1'b1, 5'd7, 32'd1, ok, hs);
        collect(1'b0, o);
        start_req(1'b0, 1'b1, 5'd7, 32'd2, ok, hs);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rsta_we_before got %b need 1", mem_we); end
        base = rsp0_cnt;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rsta_we_drop got %b need 0", mem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsta_idle got busy=%b need 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (rsp0_cnt !== base) begin n_fail++; $display("FAIL rsta_no_rsp got %0d pulses need 0", rsp0_cnt - base); end
        start_req(1'b0, 1'b0, 5'd7, 32'h0, ok, hs);
        collect(1'b0, o);
        n_checks++; if (o.rd !== 32'd1) begin n_fail++; $display("FAIL rsta_readback got %0d need 1", o.rd); end
    endtask

    task automatic test_wait_overlap();
        bit ok; int hs0; int hs1;
        start_req(1'b0, 1'b0, 5'd5, 32'h0, ok, hs0);
        @(negedge clk);
        @(negedge clk);
        req_we_1 = 1'b0; req_addr_1 = 5'd7; req_valid_1 = 1'b1;
        #1;
        n_checks++; if (req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL ovl_ready_wait got %b need 0", req_ready_1); end
        @(negedge clk); #1;
        n_checks++; if (req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL ovl_ready_resp got %b need 0", req_ready_1); end
        n_checks++; if (rsp_valid_0 !== 1'b1) begin n_fail++; $display("FAIL ovl_rsp0 got %b need 1", rsp_valid_0); end
        @(negedge clk); #1;
        n_checks++; if (req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL ovl_ready_idle got %b need 1", req_ready_1); end
        @(posedge clk); #1;
        hs1 = cyc;
        req_valid_1 = 1'b0;
        n_checks++; if (hs1 - hs0 !== 4) begin n_fail++; $display("FAIL ovl_spacing got %0d need 4", hs1 - hs0); end
        n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL ovl_grant got %b need 1", grant_id); end
        repeat (3) @(negedge clk);
        n_checks++; if (rsp_valid_1 !== 1'b1 || rsp_rdata_1 !== 32'd1) begin n_fail++; $display("FAIL ovl_rsp1 got v=%b d=%0d need v=1 d=1", rsp_valid_1, rsp_rdata_1); end
        @(negedge clk);
    endtask

    task automatic test_requester_rule();
        n_checks++; if (rule_viol !== 1'b0) begin n_fail++; $display("FAIL requester_hold got %b need 0", rule_viol); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_loader_fill();
        test_reset_during_access();
        test_wait_overlap();
        test_requester_rule();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the single-port data `Memory` (`DATA_LENGTH`×`MEM_LENGTH`). It sits between the `Memory` instance and its two users: requester 0 is the core load/store path, driven by `Control_Unit` / `register_file`, and requester 1 is the program loader/debug port. It accepts one request at a time over a valid/ready handshake, grants round-robin when both requesters are valid, and sequences the synchronous-read memory. It returns read data, or a write acknowledge, on a one-cycle response pulse.

## Interface
Parameters:
- `DATA_LENGTH`, default 32: data word width.
- `MEM_LENGTH`, default 32: memory depth in words.
- `ADDR_W`, default `$clog2(MEM_LENGTH)`: derived address width. Not to be overridden.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
  - `clk`  in  1: sole clock; all state changes on the rising edge.
  - `rst`  in  1: asynchronous, active-high reset.
- Per requester `r` in {0,1}, suffix `_0` / `_1`:
  - `req_valid_r`  in  1: request present.
  - `req_ready_r`  out  1: request accepted this cycle.
  - `req_we_r`  in  1: 1 = write, 0 = read.
  - `req_addr_r`  in  `ADDR_W`: word address.
  - `req_wdata_r`  in  `DATA_LENGTH`: write data.
  - `rsp_valid_r`  out  1: one-cycle completion pulse.
  - `rsp_rdata_r`  out  `DATA_LENGTH`: read data; 0 for a write.
- Memory side:
  - `mem_addr`  out  `ADDR_W`: drives `Memory.addr`.
  - `mem_wdata`  out  `DATA_LENGTH`: drives `Memory.wdata`.
  - `mem_we`  out  1: drives `Memory.we`.
  - `mem_rdata`  in  `DATA_LENGTH`: from `Memory.rdata`; valid the cycle after the address is presented.
- Status:
  - `busy`  out  1: state is not IDLE.
  - `grant_id`  out  1: owner of the current or last transaction.

## Operation
- FSM states: IDLE → ACCESS → WAIT → RESP → IDLE. The FSM never stalls and never skips a state.
- IDLE:
  - `grant` is computed combinationally from `req_valid_*` and the `last_grant` pointer.
  - `req_ready_r = (state==IDLE) && grant[r]`.
  - On a handshake (valid & ready), the FSM latches `we`, `addr`, `wdata` and the requester id, sets `last_grant` to that id, and moves to ACCESS.
- Round-robin arbitration:
  - With both requesters valid, the requester that is not `last_grant` wins.
  - With one requester valid, that requester wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- ACCESS:
  - `mem_addr` and `mem_wdata` are driven from the latched request.
  - `mem_we` = latched `we`, for this one cycle only.
- WAIT:
  - `mem_addr` is held and `mem_we` = 0.
  - At the end of WAIT, the latched owner's `rsp_rdata` register captures `mem_rdata` for a read, or 0 for a write.
- RESP:
  - The owner's `rsp_valid_r` = 1 for exactly one cycle.
  - The other requester's `rsp_valid` stays 0.
- `rsp_rdata_r` holds its value until that requester's next response.
- Outside ACCESS and WAIT, `mem_addr` and `mem_wdata` hold their last values and `mem_we` = 0.
- Requester rule: `req_valid` must not depend on `req_ready`. Once asserted, `req_valid` and the payload are held until the handshake. A bench assertion checks this.
- Every address in 0..`MEM_LENGTH`-1 is legal. There is no range check; when `MEM_LENGTH` is not a power of two, an out-of-range address is passed through unchanged.

## Timing
- Handshake at edge N: ACCESS in cycle N+1, WAIT in N+2, RESP (`rsp_valid`) in N+3, IDLE again in N+4.
- Throughput: at most one access every 4 cycles. The earliest next handshake is at the end of cycle N+4.
- Write: committed at the edge ending cycle N+1. A read of the same address accepted afterwards returns the new data.
- Reset values, asynchronous on `rst`:
  - state = IDLE, `last_grant` = 1.
  - `mem_addr`, `mem_wdata`, `mem_we` = 0.
  - `rsp_valid_*`, `rsp_rdata_*` = 0.
  - `busy` = 0, `grant_id` = 0.
- `req_ready_*` is 0 while `rst` is high.
- Reset during any non-IDLE state: the transaction is dropped, no response is issued, and `mem_we` falls immediately. The first handshake after reset release follows the reset arbitration order.
- Simultaneous valids in the same cycle as an in-flight transaction: neither requester is ready. They are arbitrated when the FSM returns to IDLE.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t`.
  - `localparam N_REQ = 2`.
  - Requester-id constants `REQ_CPU = 0`, `REQ_DBG = 1`.
- Sub-module `rr_arbiter`: purely combinational 2-way round-robin grant from `valid[1:0]` and `last_grant`. It is instantiated once.
- `mem_arbiter` owns the FSM, the request latch, the per-requester response registers and `last_grant`.

## Test plan
- Reset → every output listed in Timing is 0. Then `req_valid_0` = `req_valid_1` = 1 → `req_ready_0` = 1 first and `grant_id` = 0.
- Requester 0 writes addr 5, data 32'hDEADBEEF → `mem_we` = 1 for exactly one cycle (N+1) with `mem_addr` = 5; `rsp_valid_0` at N+3 with `rsp_rdata_0` = 0. Then a read of addr 5 → `rsp_rdata_0` = 32'hDEADBEEF at N+3.
- Both requesters continuously valid for 6 transactions → grants alternate 0,1,0,1,0,1, with handshakes exactly 4 cycles apart.
- Requester 1 alone, reading addrs 0..31 back-to-back after a loader fill of addr×3 → each `rsp_rdata_1` = addr×3; `rsp_valid_0` is never asserted.
- `rst` pulsed during the ACCESS cycle of a write to addr 7 (old value 1, new value 2) → `mem_we` drops within the cycle, no `rsp_valid`, FSM in IDLE, and a later read of addr 7 returns 1.
- Requester 1 asserts valid while requester 0's transaction is in WAIT → `req_ready_1` = 0 until IDLE, then requester 1 is accepted at the next handshake (4 cycles after requester 0's).
